// File: rtl/regfile_param.sv
// regfile_param: parametrised multi-port register file.
//   clk, rst        : clock, asynchronous active-high reset
//   rd_addr/rd_data : NUM_RD packed combinational read ports
//   we0/wa0/wd0     : write port 0
//   we1/wa1/wd1     : write port 1 (wins on an address collision)
//   pc_in           : value returned for reads of PC_IDX
//   clr_req         : request a full sequential clear
//   busy            : clear engine running
//   pc_wr_err       : one-cycle flag after a write aimed at PC_IDX
module regfile_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 3,
  parameter int PC_IDX = 15,
  parameter int BYPASS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [DATA_W-1:0]        pc_in,
  input  logic                     clr_req,
  output logic                     busy,
  output logic                     pc_wr_err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] PC_ADDR  = ADDR_W'(PC_IDX);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic               busy_q, busy_d;
  logic               pc_wr_err_q, pc_wr_err_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];

  logic               idle;
  logic               wr0_en, wr1_en;
  logic               clr_we;
  logic [ADDR_W-1:0]  clr_idx;

  assign idle    = (state_q == IDLE);
  assign wr0_en  = idle && we0 && (wa0 != PC_ADDR);
  assign wr1_en  = idle && we1 && (wa1 != PC_ADDR);
  assign clr_idx = clr_cnt_q[ADDR_W-1:0];
  // PC slot still consumes a sweep cycle, it just stores nothing
  assign clr_we  = !idle && (clr_idx != PC_ADDR);

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    pc_wr_err_d = idle && ((we0 && wa0 == PC_ADDR) || (we1 && wa1 == PC_ADDR));
    if (idle) begin
      if (clr_req) begin
        state_d   = CLEAR;
        clr_cnt_d = '0;
      end
    end else begin
      if (clr_cnt_q == CNT_LAST) begin
        state_d = IDLE;
      end else begin
        clr_cnt_d = clr_cnt_q + 1'b1;
      end
    end
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_cnt_q   <= '0;
      busy_q      <= 1'b1;
      pc_wr_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      busy_q      <= busy_d;
      pc_wr_err_q <= pc_wr_err_d;
    end
  end

  // Array has no reset; port 1 is written last so it wins a collision
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx] <= '0;
    end else begin
      if (wr0_en) mem_q[wa0] <= wd0;
      if (wr1_en) mem_q[wa1] <= wd1;
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      logic [ADDR_W-1:0] a;
      a = rd_addr[p*ADDR_W +: ADDR_W];
      if (a == PC_ADDR) begin
        rd_data[p*DATA_W +: DATA_W] = pc_in;
      end else if (!idle) begin
        rd_data[p*DATA_W +: DATA_W] = '0;
      end else if (BYPASS != 0 && wr1_en && wa1 == a) begin
        rd_data[p*DATA_W +: DATA_W] = wd1;
      end else if (BYPASS != 0 && wr0_en && wa0 == a) begin
        rd_data[p*DATA_W +: DATA_W] = wd0;
      end else begin
        rd_data[p*DATA_W +: DATA_W] = mem_q[a];
      end
    end
  end

  assign busy      = busy_q;
  assign pc_wr_err = pc_wr_err_q;

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] rd_addr = '0;
  logic [95:0] rd_data, rd_data_nb;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [3:0]  wa0 = '0, wa1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic [31:0] pc_in = 32'h00000108;
  logic        clr_req = 1'b0;
  logic        busy, busy_nb, pc_wr_err, pc_wr_err_nb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_param #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .PC_IDX(15), .BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .pc_in(pc_in), .clr_req(clr_req), .busy(busy), .pc_wr_err(pc_wr_err)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(4), .NUM_RD(3), .PC_IDX(15), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .we0(we0), .wa0(wa0), .wd0(wd0), .we1(we1), .wa1(wa1), .wd1(wd1),
    .pc_in(pc_in), .clr_req(clr_req), .busy(busy_nb), .pc_wr_err(pc_wr_err_nb)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rd(input int p);
    return rd_data[p*32 +: 32];
  endfunction

  function automatic logic [31:0] rd_nb(input int p);
    return rd_data_nb[p*32 +: 32];
  endfunction

  // Counts edges until busy drops, starting with busy already high
  task automatic count_busy(input string tag, input int wr_cycle, input int late_cycle);
    int n;
    n = 1;
    for (int k = 0; k < 40; k++) begin
      if (n == wr_cycle) begin
        we0 = 1'b1; wa0 = 4'd7; wd0 = 32'h77777777;
      end else if (n == late_cycle) begin
        we0 = 1'b1; wa0 = 4'd3; wd0 = 32'h33333333;
      end else begin
        we0 = 1'b0;
      end
      step();
      if (!busy) break;
      n++;
    end
    we0 = 1'b0;
    check(tag, 32'(n), 32'd16);
    check({tag, "_nb"}, {31'd0, busy_nb}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    for (int r = 0; r < 15; r++) begin
      rd_addr = {4'd15, 4'd15, 4'(r)};
      #1;
      check($sformatf("%s_r%0d", tag, r), rd(0), 32'd0);
    end
  endtask

  initial begin
    // Reset clear
    step();
    step();
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_pcerr", {31'd0, pc_wr_err}, 32'd0);
    count_busy("reset_busy_len", -1, -1);
    rd_addr = {4'd2, 4'd1, 4'd0};
    #1;
    check("rst_rd0", rd(0), 32'd0);
    check("rst_rd1", rd(1), 32'd0);
    check("rst_rd2", rd(2), 32'd0);
    rd_addr = {4'd0, 4'd0, 4'd15};
    #1;
    check("pc_read", rd(0), 32'h00000108);

    // Dual write collision
    we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hAAAA0000;
    we1 = 1'b1; wa1 = 4'd3; wd1 = 32'h5555FFFF;
    step();
    we0 = 1'b0; we1 = 1'b0;
    rd_addr = {4'd0, 4'd0, 4'd3};
    #1;
    check("collide_r3", rd(0), 32'h5555FFFF);
    check("collide_r3_nb", rd_nb(0), 32'h5555FFFF);
    we0 = 1'b1; wa0 = 4'd3; wd0 = 32'hAAAA0000;
    we1 = 1'b1; wa1 = 4'd4; wd1 = 32'h5555FFFF;
    step();
    we0 = 1'b0; we1 = 1'b0;
    rd_addr = {4'd3, 4'd4, 4'd3};
    #1;
    check("split_r3", rd(0), 32'hAAAA0000);
    check("split_r4", rd(1), 32'h5555FFFF);
    check("split_r3_p2", rd(2), 32'hAAAA0000);

    // Bypass vs. no bypass
    rd_addr = {4'd0, 4'd0, 4'd5};
    we0 = 1'b1; wa0 = 4'd5; wd0 = 32'h00020200;
    #1;
    check("bypass_same", rd(0), 32'h00020200);
    check("nobypass_same", rd_nb(0), 32'd0);
    step();
    we0 = 1'b0;
    #1;
    check("nobypass_next", rd_nb(0), 32'h00020200);
    rd_addr = {4'd0, 4'd6, 4'd6};
    we0 = 1'b1; wa0 = 4'd6; wd0 = 32'h00000A0A;
    we1 = 1'b1; wa1 = 4'd6; wd1 = 32'h00000B0B;
    #1;
    check("bypass_prio", rd(1), 32'h00000B0B);
    step();
    we0 = 1'b0; we1 = 1'b0;

    // PC protection
    we0 = 1'b1; wa0 = 4'd15; wd0 = 32'h0000DEAD;
    rd_addr = {4'd5, 4'd4, 4'd15};
    #1;
    check("pcw_before", {31'd0, pc_wr_err}, 32'd0);
    check("pcw_bypass", rd(0), 32'h00000108);
    step();
    we0 = 1'b0;
    check("pcw_err", {31'd0, pc_wr_err}, 32'd1);
    check("pcw_r15", rd(0), 32'h00000108);
    check("pcw_r4", rd(1), 32'h5555FFFF);
    check("pcw_r5", rd(2), 32'h00020200);
    step();
    check("pcw_err_clr", {31'd0, pc_wr_err}, 32'd0);

    // Fill, then clear by request with writes attempted mid-sweep
    for (int r = 0; r < 15; r++) begin
      we0 = 1'b1; wa0 = 4'(r); wd0 = 32'h100 + 32'(r);
      step();
    end
    we0 = 1'b0;
    rd_addr = {4'd0, 4'd0, 4'd7};
    #1;
    check("fill_r7", rd(0), 32'h00000107);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("clr_busy", {31'd0, busy}, 32'd1);
    check("clr_read0", rd(0), 32'd0);
    count_busy("clr_busy_len", 3, 12);
    check_all_zero("clr");

    // Reset in the middle of a sweep
    we0 = 1'b1; wa0 = 4'd12; wd0 = 32'hC0C0C0C0;
    step();
    we0 = 1'b0;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 1; k < 9; k++) step();
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd1);
    step();
    rst = 1'b0;
    count_busy("midrst_busy_len", -1, -1);
    check_all_zero("midrst");
    rd_addr = {4'd0, 4'd0, 4'd15};
    pc_in = 32'h00002008;
    #1;
    check("final_pc", rd(0), 32'h00002008);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
